alu_flag_unit: RTL and testbench
================================

Name: alu_flag_unit

Overview:
- Sits directly downstream of the 8-bit ALU. Captures the ALU result, carry, overflow and compare-enable into a registered Z/C/V/N flags register.
- Feeds C back to the ALU carry input for multi-byte chained compares.
- Evaluates the control unit's conditional-jump codes against the registered flags.
- Holds a small flag stack so interrupt/call sequences can save and restore flags.

Parameters:
- STACK_DEPTH, 4, number of 4-bit flag entries in the save stack (2..16).
- CW, 3, width of the stack count output; must hold 0..STACK_DEPTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alu_out  input  8  ALU result bus
- alu_carry  input  1  ALU carry out
- alu_over  input  1  ALU signed overflow
- alu_cmp  input  1  ALU compare/capture enable; flags update when high
- chain  input  1  multi-byte compare; Z accumulates instead of overwriting
- cond  input  4  jump condition code
- eval  input  1  strobe: evaluate cond this cycle
- push  input  1  push current flags onto stack
- pop  input  1  pop stack into flags
- flags  output  4  {N,V,C,Z}, registered
- carry_fb  output  1  to ALU carryin, equals flags C
- take  output  1  jump decision, valid when take_valid
- take_valid  output  1  one-cycle pulse, one cycle after eval
- stk_count  output  CW  entries in use
- stk_full  output  1  stk_count == STACK_DEPTH
- stk_empty  output  1  stk_count == 0
- stk_err  output  1  sticky stack error

Behaviour:
- Reset, async, immediate: flags=0, take=0, take_valid=0, stk_count=0, stk_err=0. Stack contents are don't-care.

Capture (rising clk, when alu_cmp=1 and pop=0):
- Z = (alu_out==0), or Z_old & (alu_out==0) when chain=1.
- C = alu_carry.
- V = alu_over.
- N = alu_out[7].
- alu_cmp=0: flags hold.

Carry feedback:
- carry_fb is the registered C, combinational from the flag register.
- Flag priority per cycle: rst > pop > capture > hold.

Stack:
- push, not full: writes the pre-edge flags value; count+1.
- pop, not empty: flags <= top entry; count-1.
- push with capture in the same cycle: both happen. The stack gets the old flags; the flags register gets the new capture.
- push and pop in the same cycle: no stack or flag change; stk_err set.
- push when full, or pop when empty: ignored (no change); stk_err set.
- stk_err clears only on rst.

Jump evaluation:
- take registered at the edge where eval=1, from the flags value before that edge. take_valid=1 for exactly that next cycle. take holds its value until the next eval.
- Codes:
  - 0: always
  - 1: Z
  - 2: !Z
  - 3: C
  - 4: !C
  - 5: N
  - 6: !N
  - 7: V
  - 8: !V
  - 9: C&!Z (unsigned >)
  - 10: !C|Z (unsigned <=)
  - 11: N==V (signed >=)
  - 12: N!=V (signed <)
  - 13: !Z&(N==V) (signed >)
  - 14: Z|(N!=V) (signed <=)
  - 15: never
- eval with capture in the same cycle uses the old flags.
- Back-to-back evals produce back-to-back take_valid pulses.
- Reset asserted mid-operation clears everything at once, including a pending take_valid.

Test Plan:
- Capture: alu_out=0x00, carry=1, over=0, alu_cmp=1 -> next cycle flags={N0,V0,C1,Z1}, carry_fb=1. Repeat with alu_cmp=0 and alu_out=0x80 -> flags unchanged.
- Chain: byte0 out=0x00 (chain=0), byte1 out=0x05 (chain=1) -> Z=0. Byte0 0x00 then byte1 0x00 (chain=1) -> Z=1. Byte0 0x03 then byte1 0x00 (chain=1) -> Z stays 0.
- Conditions, flags={N1,V0,C0,Z0}: cond=12 -> take=1; cond=11 -> take=0; cond=10 -> take=1; cond=0 -> 1; cond=15 -> 0. take_valid is exactly one cycle after each eval.
- Stack, STACK_DEPTH=4: push 4 distinct flag values -> stk_full=1. 5th push -> ignored, stk_err=1. 4 pops restore values in LIFO order, stk_empty=1. Extra pop -> flags unchanged.
- Simultaneous: push+capture with flags=0x3 and new capture yielding 0x8 -> top entry=0x3, flags=0x8. push+pop together -> count unchanged, stk_err=1.
- Async reset mid-sequence, with count=2 and take_valid pending -> all outputs 0 immediately without a clock edge. First push after reset gives count=1.

Source files
------------

// File: rtl/alu_flag_unit.sv
// alu_flag_unit
//   Registered Z/C/V/N flags captured from the 8-bit ALU, carry feedback for
//   chained multi-byte compares, conditional-jump evaluation against the
//   registered flags, and a small LIFO for saving/restoring flags.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   alu_out/carry/over  ALU result, carry out, signed overflow
//   alu_cmp, chain      capture enable; chain makes Z accumulate across bytes
//   cond, eval          jump condition code and evaluate strobe
//   push, pop           flag stack save/restore requests
//   flags               {N,V,C,Z}, registered
//   carry_fb            registered C back to the ALU carry input
//   take, take_valid    jump decision and its one-cycle valid pulse
//   stk_count/full/empty/err  stack occupancy and sticky error
module alu_flag_unit #(
  parameter int STACK_DEPTH = 4,
  parameter int CW          = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    alu_out,
  input  logic          alu_carry,
  input  logic          alu_over,
  input  logic          alu_cmp,
  input  logic          chain,
  input  logic [3:0]    cond,
  input  logic          eval,
  input  logic          push,
  input  logic          pop,
  output logic [3:0]    flags,
  output logic          carry_fb,
  output logic          take,
  output logic          take_valid,
  output logic [CW-1:0] stk_count,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          stk_err
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    CC_ALWAYS = 4'd0,  CC_Z   = 4'd1,  CC_NZ  = 4'd2,  CC_C   = 4'd3,
    CC_NC     = 4'd4,  CC_N   = 4'd5,  CC_NN  = 4'd6,  CC_V   = 4'd7,
    CC_NV     = 4'd8,  CC_HI  = 4'd9,  CC_LS  = 4'd10, CC_GE  = 4'd11,
    CC_LT     = 4'd12, CC_GT  = 4'd13, CC_LE  = 4'd14, CC_NEVER = 4'd15
  } cond_t;

  logic [3:0]    stk_mem [STACK_DEPTH];
  logic          f_n, f_v, f_c, f_z;
  logic          cond_true;
  logic          res_zero;
  logic [3:0]    cap_flags;
  logic          push_ok, pop_ok, conflict;
  logic [CW-1:0] top_idx;

  assign {f_n, f_v, f_c, f_z} = flags;
  assign carry_fb  = f_c;
  assign stk_full  = (stk_count == CW'(STACK_DEPTH));
  assign stk_empty = (stk_count == '0);

  assign res_zero  = (alu_out == 8'h00);
  // Chained compare: Z survives only if every byte so far was zero.
  assign cap_flags = {alu_out[7], alu_over, alu_carry, chain ? (f_z & res_zero) : res_zero};

  assign conflict = push & pop;
  assign push_ok  = push & ~pop & ~stk_full;
  assign pop_ok   = pop & ~push & ~stk_empty;
  assign top_idx  = stk_count - CW'(1);

  always_comb begin
    cond_true = 1'b0;
    case (cond_t'(cond))
      CC_ALWAYS: cond_true = 1'b1;
      CC_Z:      cond_true = f_z;
      CC_NZ:     cond_true = ~f_z;
      CC_C:      cond_true = f_c;
      CC_NC:     cond_true = ~f_c;
      CC_N:      cond_true = f_n;
      CC_NN:     cond_true = ~f_n;
      CC_V:      cond_true = f_v;
      CC_NV:     cond_true = ~f_v;
      CC_HI:     cond_true = f_c & ~f_z;
      CC_LS:     cond_true = ~f_c | f_z;
      CC_GE:     cond_true = (f_n == f_v);
      CC_LT:     cond_true = (f_n != f_v);
      CC_GT:     cond_true = ~f_z & (f_n == f_v);
      CC_LE:     cond_true = f_z | (f_n != f_v);
      CC_NEVER:  cond_true = 1'b0;
      default:   cond_true = 1'b0;
    endcase
  end

  // Stack storage carries no reset; its contents are meaningless when empty.
  always_ff @(posedge clk) begin
    if (push_ok) stk_mem[stk_count[AW-1:0]] <= flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags      <= '0;
      take       <= 1'b0;
      take_valid <= 1'b0;
      stk_count  <= '0;
      stk_err    <= 1'b0;
    end else begin
      take_valid <= eval;
      if (eval) take <= cond_true;

      if ((push & stk_full) | (pop & stk_empty) | conflict) stk_err <= 1'b1;

      // Pop outranks capture; a push/pop conflict leaves flags untouched.
      if (pop_ok)
        flags <= stk_mem[top_idx[AW-1:0]];
      else if (alu_cmp & ~pop)
        flags <= cap_flags;

      if (push_ok)
        stk_count <= stk_count + CW'(1);
      else if (pop_ok)
        stk_count <= stk_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: capture, chaining, jump conditions,
// flag stack, simultaneous operations and asynchronous reset.
module tb_alu_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_out;
  logic       alu_carry, alu_over, alu_cmp, chain;
  logic [3:0] cond;
  logic       eval, push, pop;
  logic [3:0] flags;
  logic       carry_fb, take, take_valid;
  logic [2:0] stk_count;
  logic       stk_full, stk_empty, stk_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  alu_flag_unit #(.STACK_DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .alu_carry(alu_carry),
    .alu_over(alu_over), .alu_cmp(alu_cmp), .chain(chain), .cond(cond),
    .eval(eval), .push(push), .pop(pop), .flags(flags), .carry_fb(carry_fb),
    .take(take), .take_valid(take_valid), .stk_count(stk_count),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [7:0] o, input logic c, input logic v, input logic ch);
    alu_out = o; alu_carry = c; alu_over = v; chain = ch; alu_cmp = 1'b1;
    step();
    alu_cmp = 1'b0; chain = 1'b0;
  endtask

  task automatic do_eval(input logic [3:0] cc);
    cond = cc; eval = 1'b1;
    step();
    eval = 1'b0;
  endtask

  task automatic do_push();
    push = 1'b1; step(); push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1; step(); pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_out = '0; alu_carry = 0; alu_over = 0; alu_cmp = 0;
    chain = 0; cond = '0; eval = 0; push = 0; pop = 0;
    #12;
    chk("rst_flags", {4'h0, flags}, 8'h00);
    chk("rst_take_valid", {7'h0, take_valid}, 8'h00);
    chk("rst_count", {5'h0, stk_count}, 8'h00);
    chk("rst_empty", {7'h0, stk_empty}, 8'h01);
    @(negedge clk); rst = 1'b0;

    // Capture and hold
    cap(8'h00, 1, 0, 0);
    chk("cap_flags", {4'h0, flags}, 8'h03);
    chk("cap_carry_fb", {7'h0, carry_fb}, 8'h01);
    alu_out = 8'h80; alu_carry = 0; step();
    chk("hold_flags", {4'h0, flags}, 8'h03);

    // Chained compares
    cap(8'h00, 0, 0, 0); cap(8'h05, 0, 0, 1);
    chk("chain_00_05", {4'h0, flags}, 8'h00);
    cap(8'h00, 0, 0, 0); cap(8'h00, 0, 0, 1);
    chk("chain_00_00", {4'h0, flags}, 8'h01);
    cap(8'h03, 0, 0, 0); cap(8'h00, 0, 0, 1);
    chk("chain_03_00", {4'h0, flags}, 8'h00);

    // Conditions with {N1,V0,C0,Z0}, back-to-back evals
    cap(8'h80, 0, 0, 0);
    chk("cond_setup", {4'h0, flags}, 8'h08);
    cond = 4'd12; eval = 1; step();
    chk("c12_take", {7'h0, take}, 8'h01); chk("c12_tv", {7'h0, take_valid}, 8'h01);
    cond = 4'd11; step();
    chk("c11_take", {7'h0, take}, 8'h00); chk("c11_tv", {7'h0, take_valid}, 8'h01);
    cond = 4'd10; step();
    chk("c10_take", {7'h0, take}, 8'h01);
    cond = 4'd0; step();
    chk("c0_take", {7'h0, take}, 8'h01);
    cond = 4'd15; step();
    chk("c15_take", {7'h0, take}, 8'h00);
    eval = 0; step();
    chk("tv_drop", {7'h0, take_valid}, 8'h00);
    chk("take_hold", {7'h0, take}, 8'h00);

    // Eval with capture in same cycle uses old flags (N=1)
    cond = 4'd5; eval = 1; alu_out = 8'h01; alu_carry = 0; alu_over = 0; alu_cmp = 1;
    step(); eval = 0; alu_cmp = 0;
    chk("eval_old_take", {7'h0, take}, 8'h01);
    chk("eval_cap_flags", {4'h0, flags}, 8'h00);

    // Stack fill
    cap(8'h00, 1, 0, 0); do_push();
    cap(8'h80, 0, 1, 0); do_push();
    cap(8'h01, 1, 0, 0); do_push();
    cap(8'h00, 0, 1, 0); do_push();
    chk("fill_full", {7'h0, stk_full}, 8'h01);
    chk("fill_err", {7'h0, stk_err}, 8'h00);
    do_push();
    chk("over_count", {5'h0, stk_count}, 8'h04);
    chk("over_err", {7'h0, stk_err}, 8'h01);
    do_pop(); chk("pop1", {4'h0, flags}, 8'h05);
    do_pop(); chk("pop2", {4'h0, flags}, 8'h02);
    do_pop(); chk("pop3", {4'h0, flags}, 8'h0C);
    do_pop(); chk("pop4", {4'h0, flags}, 8'h03);
    chk("pop_empty", {7'h0, stk_empty}, 8'h01);
    do_pop();
    chk("under_flags", {4'h0, flags}, 8'h03);
    chk("under_count", {5'h0, stk_count}, 8'h00);

    // Fresh start for simultaneous operations
    #2 rst = 1'b1; #1 rst = 1'b0;
    chk("rst2_err", {7'h0, stk_err}, 8'h00);
    cap(8'h00, 1, 0, 0); do_push();
    chk("pp_pre_count", {5'h0, stk_count}, 8'h01);
    push = 1; pop = 1; step(); push = 0; pop = 0;
    chk("pp_count", {5'h0, stk_count}, 8'h01);
    chk("pp_err", {7'h0, stk_err}, 8'h01);
    chk("pp_flags", {4'h0, flags}, 8'h03);
    push = 1; alu_out = 8'h80; alu_carry = 0; alu_over = 0; alu_cmp = 1;
    step(); push = 0; alu_cmp = 0;
    chk("pcap_flags", {4'h0, flags}, 8'h08);
    chk("pcap_count", {5'h0, stk_count}, 8'h02);
    do_pop();
    chk("pcap_top", {4'h0, flags}, 8'h03);
    do_push();
    do_eval(4'd0);
    chk("pend_tv", {7'h0, take_valid}, 8'h01);
    chk("pend_count", {5'h0, stk_count}, 8'h02);

    // Async reset between edges
    #2 rst = 1'b1; #1;
    chk("arst_flags", {4'h0, flags}, 8'h00);
    chk("arst_carry_fb", {7'h0, carry_fb}, 8'h00);
    chk("arst_take", {7'h0, take}, 8'h00);
    chk("arst_tv", {7'h0, take_valid}, 8'h00);
    chk("arst_count", {5'h0, stk_count}, 8'h00);
    chk("arst_err", {7'h0, stk_err}, 8'h00);
    chk("arst_full", {7'h0, stk_full}, 8'h00);
    rst = 1'b0;
    do_push();
    chk("post_push_count", {5'h0, stk_count}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
